// File: rtl/ahb_lite_interconnect_dec_pkg.sv
// Shared AHB-Lite definitions for the interconnect decoder: transfer and
// response encodings, the default-slave state enum, the default slave map
// and the registered data-phase select type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } dflt_state_e;

  localparam int DEF_N_SLV = 4;
  localparam logic [DEF_N_SLV*32-1:0] DEF_SLV_BASE =
    {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [DEF_N_SLV*32-1:0] DEF_SLV_MASK = {DEF_N_SLV{32'hF000_0000}};

  // Data-phase owner: a real slot index, or the internal default slave
  typedef struct packed {
    logic       isDflt;
    logic [3:0] idx;
  } sel_t;

  // NONSEQ and SEQ both carry HTRANS[1]; IDLE and BUSY never need a response
  function automatic logic isActiveTrans(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_lite_interconnect_dec_if.sv
// Bus bundle between the single AHB-Lite master side and the decoder.
// The master modport is the view of whatever drives the bus and the slave
// array; the slave modport is the decoder's own view.
interface ahb_lite_interconnect_dec_if #(
  parameter int N_SLV  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]       HADDR;
  logic [1:0]              HTRANS;
  logic                    HREADY;
  logic [N_SLV-1:0]        HSELx;
  logic [N_SLV*DATA_W-1:0] HRDATA_S;
  logic [N_SLV-1:0]        HREADYOUT_S;
  logic [N_SLV-1:0]        HRESP_S;
  logic [DATA_W-1:0]       HRDATA;
  logic                    HREADYOUT;
  logic                    HRESP;

  modport master (
    output HADDR, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HSELx, HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HREADY, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HSELx, HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_interconnect_dec_default_slave.sv
// Internal default slave: answers every active transfer to unmapped space
// with the two-cycle AHB ERROR response and flags the first cycle on dsError.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic errTrigger,
  output logic dsReadyOut,
  output logic dsResp,
  output logic dsError
);

  dflt_state_e state;

  // Step through IDLE -> ERR1 -> ERR2 with the response outputs registered alongside the state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= DS_IDLE;
      dsReadyOut <= 1'b1;
      dsResp     <= HRESP_OKAY;
      dsError    <= 1'b0;
    end else begin
      case (state)
        DS_ERR1: begin
          state      <= DS_ERR2;
          dsReadyOut <= 1'b1;
          dsResp     <= HRESP_ERROR;
          dsError    <= 1'b0;
        end
        DS_IDLE, DS_ERR2: begin
          if (errTrigger) begin
            state      <= DS_ERR1;
            dsReadyOut <= 1'b0;
            dsResp     <= HRESP_ERROR;
            dsError    <= 1'b1;
          end else begin
            state      <= DS_IDLE;
            dsReadyOut <= 1'b1;
            dsResp     <= HRESP_OKAY;
            dsError    <= 1'b0;
          end
        end
        default: begin
          state      <= DS_IDLE;
          dsReadyOut <= 1'b1;
          dsResp     <= HRESP_OKAY;
          dsError    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_lite_interconnect_dec.sv
// AHB-Lite address decoder and response multiplexer for N_SLV slaves.
// Address-phase decode drives HSELx, the data-phase owner is registered in
// selQ, and unmapped transfers are answered by ahb_default_slave.
// Optional error address log enabled by defining AHB_DEC_ERRLOG_EN.
module ahb_lite_interconnect_dec
  import ahb_pkg::*;
#(
  parameter int N_SLV  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_lite_interconnect_dec_if.slave bus,
  input  logic                ERR_CLR,
  output logic                HERROR,
  output logic [ADDR_W-1:0]   ERR_ADDR,
  output logic                ERR_VALID
);

  logic       addrHit;
  logic [3:0] hitIdx;
  logic       errTrigger;
  sel_t       selQ;
  logic       dsReadyOut;
  logic       dsResp;
  logic       dsError;
  logic       unusedTransLsb;

  assign unusedTransLsb = bus.HTRANS[0];

  // Priority decode: scan from the top so the lowest matching slot is written last and wins
  always_comb begin
    addrHit   = 1'b0;
    hitIdx    = '0;
    bus.HSELx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        addrHit = 1'b1;
        hitIdx  = i[3:0];
      end
    end
    for (int i = 0; i < N_SLV; i++) begin
      bus.HSELx[i] = addrHit && (hitIdx == i[3:0]);
    end
  end

  assign errTrigger = bus.HREADY && !addrHit && isActiveTrans(bus.HTRANS);

  // Capture the data-phase owner whenever the bus accepts an address phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      selQ <= {1'b1, 4'd0};
    end else if (bus.HREADY) begin
      selQ <= {!addrHit, hitIdx};
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .errTrigger (errTrigger),
    .dsReadyOut (dsReadyOut),
    .dsResp     (dsResp),
    .dsError    (dsError)
  );

  assign HERROR = dsError;

  // Return the data-phase owner's response; the default slave never returns read data
  always_comb begin
    bus.HRDATA    = '0;
    bus.HREADYOUT = dsReadyOut;
    bus.HRESP     = dsResp;
    if (!selQ.isDflt) begin
      for (int i = 0; i < N_SLV; i++) begin
        if (selQ.idx == i[3:0]) begin
          bus.HRDATA    = bus.HRDATA_S[i*DATA_W +: DATA_W];
          bus.HREADYOUT = bus.HREADYOUT_S[i];
          bus.HRESP     = bus.HRESP_S[i];
        end
      end
    end
  end

`ifdef AHB_DEC_ERRLOG_EN
  logic              errValidQ;
  logic [ADDR_W-1:0] errAddrQ;

  // Keep the first failing address until cleared; a capture coinciding with a clear takes the new address
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      errValidQ <= 1'b0;
      errAddrQ  <= '0;
    end else if (errTrigger && (!errValidQ || ERR_CLR)) begin
      errValidQ <= 1'b1;
      errAddrQ  <= bus.HADDR;
    end else if (ERR_CLR) begin
      errValidQ <= 1'b0;
    end
  end

  assign ERR_VALID = errValidQ;
  assign ERR_ADDR  = errAddrQ;
`else
  logic unusedErrClr;
  assign unusedErrClr = ERR_CLR;
  assign ERR_VALID    = 1'b0;
  assign ERR_ADDR     = '0;
`endif

endmodule

// File: tb/tb_ahb_lite_interconnect_dec.sv
// Scoreboard bench for ahb_lite_interconnect_dec: a transaction-level model
// predicts each cycle's outputs into a queue and a monitor compares them.
// Honours AHB_DEC_ERRLOG_EN for the error log expectations.
module tb_ahb_lite_interconnect_dec;
  import ahb_pkg::*;

  localparam int N_SLV      = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int NUM_RANDOM = 3000;

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [1:0]              trans;
    logic [N_SLV*DATA_W-1:0] rdata;
    logic [N_SLV-1:0]        rdy;
    logic [N_SLV-1:0]        resp;
    logic                    rst;
    logic                    clr;
  } stim_t;

  typedef struct packed {
    logic [N_SLV-1:0]  hsel;
    logic [DATA_W-1:0] rdata;
    logic              rdy;
    logic              resp;
    logic              herr;
    logic              errValid;
    logic [ADDR_W-1:0] errAddr;
  } exp_t;

  typedef enum int {DP_OKAY, DP_SLOT, DP_ERR_FIRST, DP_ERR_SECOND} dp_e;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic              ERR_CLR;
  logic              HERROR;
  logic [ADDR_W-1:0] ERR_ADDR;
  logic              ERR_VALID;

  int numChecks = 0;
  int numFails  = 0;
  int cycleNum  = 0;

  exp_t  expQ[$];
  stim_t prevStim;

  dp_e               mKind;
  int                mSlot;
  logic              mReady;
  logic              mErrValid;
  logic [ADDR_W-1:0] mErrAddr;

  logic [ADDR_W-1:0] refBase [N_SLV];
  logic [ADDR_W-1:0] refMask;

  ahb_lite_interconnect_dec_if #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.HREADY = bus.HREADYOUT;

  ahb_lite_interconnect_dec #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus.slave),
    .ERR_CLR   (ERR_CLR),
    .HERROR    (HERROR),
    .ERR_ADDR  (ERR_ADDR),
    .ERR_VALID (ERR_VALID)
  );

  always #5 HCLK = ~HCLK;

  function automatic int refSlot(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < N_SLV; i++) begin
      if ((a & refMask) == (refBase[i] & refMask)) return i;
    end
    return -1;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.addr  = '0;
    s.trans = HTRANS_IDLE;
    for (int i = 0; i < N_SLV; i++) s.rdata[i*DATA_W +: DATA_W] = $urandom;
    s.rdy   = '1;
    s.resp  = '0;
    s.rst   = 1'b0;
    s.clr   = 1'b0;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    int nib;
    s = idleStim();
    s.addr = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      nib = $urandom_range(0, 3);
      if (nib == 3) nib = 4;
    end else begin
      nib = $urandom_range(5, 15);
      if ($urandom_range(0, 4) == 0) nib = 3;
    end
    s.addr[31:28] = nib[3:0];
    s.trans = 2'($urandom_range(0, 3));
    for (int i = 0; i < N_SLV; i++) begin
      s.rdy[i]  = ($urandom_range(0, 9) < 7);
      s.resp[i] = ($urandom_range(0, 19) == 0);
    end
    s.rst = ($urandom_range(0, 99) == 0);
    s.clr = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Advance the transaction model across one clock edge using the inputs held during the cycle before it
  task automatic updateModel(input stim_t s);
    int slot;
    if (s.rst) begin
      mKind     = DP_OKAY;
      mSlot     = 0;
      mErrValid = 1'b0;
      mErrAddr  = '0;
      return;
    end
    slot = refSlot(s.addr);
`ifdef AHB_DEC_ERRLOG_EN
    if (mReady && slot < 0 && s.trans[1]) begin
      if (!mErrValid || s.clr) begin
        mErrValid = 1'b1;
        mErrAddr  = s.addr;
      end
    end else if (s.clr) begin
      mErrValid = 1'b0;
    end
`endif
    if (mReady) begin
      if (slot >= 0) begin
        mKind = DP_SLOT;
        mSlot = slot;
      end else if (s.trans[1]) begin
        mKind = DP_ERR_FIRST;
      end else begin
        mKind = DP_OKAY;
      end
    end else if (mKind == DP_ERR_FIRST) begin
      mKind = DP_ERR_SECOND;
    end
  endtask

  // Drive one cycle of stimulus right after the edge and queue the outputs the model predicts for it
  task automatic applyStimulus(input stim_t n);
    exp_t e;
    int   slot;
    @(posedge HCLK);
    #1;
    updateModel(prevStim);
    HRESET          = n.rst;
    ERR_CLR         = n.clr;
    bus.HADDR       = n.addr;
    bus.HTRANS      = n.trans;
    bus.HRDATA_S    = n.rdata;
    bus.HREADYOUT_S = n.rdy;
    bus.HRESP_S     = n.resp;
    slot   = refSlot(n.addr);
    e.hsel = (slot >= 0) ? N_SLV'(1 << slot) : '0;
    case (mKind)
      DP_SLOT: begin
        e.rdata = n.rdata[mSlot*DATA_W +: DATA_W];
        e.rdy   = n.rdy[mSlot];
        e.resp  = n.resp[mSlot];
        e.herr  = 1'b0;
      end
      DP_ERR_FIRST: begin
        e.rdata = '0; e.rdy = 1'b0; e.resp = 1'b1; e.herr = 1'b1;
      end
      DP_ERR_SECOND: begin
        e.rdata = '0; e.rdy = 1'b1; e.resp = 1'b1; e.herr = 1'b0;
      end
      default: begin
        e.rdata = '0; e.rdy = 1'b1; e.resp = 1'b0; e.herr = 1'b0;
      end
    endcase
    e.errValid = mErrValid;
    e.errAddr  = mErrAddr;
    mReady     = e.rdy;
    expQ.push_back(e);
    prevStim = n;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    numChecks++;
    if (act !== req) begin
      numFails++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleNum, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("HSELx", 32'(bus.HSELx), 32'(e.hsel));
    checkField("HRDATA", bus.HRDATA, e.rdata);
    checkField("HREADYOUT", 32'(bus.HREADYOUT), 32'(e.rdy));
    checkField("HRESP", 32'(bus.HRESP), 32'(e.resp));
    checkField("HERROR", 32'(HERROR), 32'(e.herr));
    checkField("ERR_VALID", 32'(ERR_VALID), 32'(e.errValid));
    checkField("ERR_ADDR", ERR_ADDR, e.errAddr);
  endtask

  // Monitor: mid-cycle, pop the prediction for this cycle and compare every output
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
        cycleNum++;
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    stim_t s;
    refBase[0] = 32'h0000_0000;
    refBase[1] = 32'h1000_0000;
    refBase[2] = 32'h2000_0000;
    refBase[3] = 32'h4000_0000;
    refMask    = 32'hF000_0000;
    mKind = DP_OKAY; mSlot = 0; mReady = 1'b1; mErrValid = 1'b0; mErrAddr = '0;

    s = idleStim();
    s.rst = 1'b1;
    HRESET = 1'b1; ERR_CLR = 1'b0;
    bus.HADDR = s.addr; bus.HTRANS = s.trans; bus.HRDATA_S = s.rdata;
    bus.HREADYOUT_S = s.rdy; bus.HRESP_S = s.resp;
    prevStim = s;
    $display("[TB] reset");
    applyStimulus(s);
    applyStimulus(idleStim());

    $display("[TB] mapped read from slave 1");
    s = idleStim(); s.addr = 32'h1000_0040; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    s = idleStim(); s.rdata[1*DATA_W +: DATA_W] = 32'hCAFE_F00D; applyStimulus(s);

    $display("[TB] unmapped NONSEQ");
    s = idleStim(); s.addr = 32'h8000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    $display("[TB] unmapped IDLE transfer");
    s = idleStim(); s.addr = 32'h8000_0000; s.trans = HTRANS_IDLE; applyStimulus(s);
    applyStimulus(idleStim());

    $display("[TB] slave 2 wait states");
    s = idleStim(); s.addr = 32'h2000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    repeat (3) begin
      s = idleStim(); s.addr = 32'h0000_0010; s.trans = HTRANS_NONSEQ; s.rdy[2] = 1'b0; applyStimulus(s);
    end
    s = idleStim(); s.addr = 32'h0000_0010; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    applyStimulus(idleStim());

    $display("[TB] back-to-back mapped/unmapped");
    s = idleStim(); s.addr = 32'h4000_0100; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    s = idleStim(); s.addr = 32'hC000_0000; s.trans = HTRANS_SEQ; applyStimulus(s);
    s = idleStim(); s.addr = 32'h1000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    s = idleStim(); s.addr = 32'h1000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    applyStimulus(idleStim());

    $display("[TB] reset during ERR1");
    s = idleStim(); s.addr = 32'h8000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    s = idleStim(); s.rst = 1'b1; applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    $display("[TB] error log sequence");
    s = idleStim(); s.addr = 32'h9000_0004; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    s = idleStim(); s.addr = 32'hA000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    s = idleStim(); s.addr = 32'hA000_0000; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    repeat (3) applyStimulus(idleStim());
    s = idleStim(); s.clr = 1'b1; applyStimulus(s);
    applyStimulus(idleStim());
    s = idleStim(); s.addr = 32'hB000_0008; s.trans = HTRANS_NONSEQ; applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    $display("[TB] randomized run");
    for (int i = 0; i < NUM_RANDOM; i++) applyStimulus(randStim());
    applyStimulus(idleStim());

    @(negedge HCLK);
    #1;
    checkField("queueDrained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
